caesar_cipher_pipeline: RTL and testbench
=========================================

// Module: caesar_cipher_pipeline
// PURPOSE
//   N-stage pipelined Caesar cipher engine; successor to the fixed 3-stage cipher.
//   Streams one 8-bit ASCII char/cycle over a valid/ready handshake, one register per stage.
//   Per-char keys, direction and mode travel with the data.
//   Sits between the char source (UART/host FIFO) and the ciphertext sink.
// PARAMETERS
//   NUM_STAGES        3    number of shift stages (1..8); also pipeline depth
//   PASS_NON_LETTERS  0    1: non-letter chars pass unchanged, no error; 0: flagged as char error
//   ERR_CNT_W         16   width of saturating error counter
// PORTS
//   clk                 in   1             clock, all state on rising edge
//   rst_n               in   1             asynchronous active-low reset
//   in_valid            in   1             input char/keys valid
//   in_ready            out  1             engine can accept this cycle
//   in_char             in   8             input ASCII char
//   in_decrypt          in   1             0 encrypt, 1 decrypt
//   in_key_num          in   5*NUM_STAGES  stage i shift at [5i+4:5i], legal 0..25
//   in_key_dir          in   NUM_STAGES    stage i direction, 0 right(+), 1 left(-)
//   out_valid           out  1             result valid
//   out_ready           in   1             sink accepts result
//   out_char            out  8             cipher/plain char, 8'h00 on error
//   out_err_key         out  1             some in_key_num field > 25
//   out_err_char        out  1             char not A-Z/a-z and PASS_NON_LETTERS=0
//   err_count           out  ERR_CNT_W     chars delivered with any error, saturating
// BEHAVIOUR
//   Reset: all stage valid bits, out_valid, out_char, out_err_*, err_count -> 0; in_ready=1 after reset.
//   Handshake: transfer on valid&&ready at a clock edge.
//   - Global enable: en = !out_valid || out_ready.
//   - in_ready = en, combinational.
//   - in_char/keys/dir/mode are not required stable after accept.
//   - out_* stay stable while out_valid && !out_ready.
//   Latency: accept at edge t -> out_valid from edge t+NUM_STAGES when en stays high.
//     Throughput 1 char/cycle; bubbles propagate and are not collapsed.
//   Stage 0 (input edge):
//     - classify char: upper 0x41-0x5A, lower 0x61-0x7A
//     - compute err_key, err_char
//     - capture all keys and directions with the char
//   Stage i (i=0..NUM_STAGES-1):
//     - effective direction = in_key_dir[i] XOR in_decrypt
//     - right: c = c + k; if c > 'Z'/'z' (per captured case), c -= 26
//     - left: c = c - k; if c < 'A'/'a', c += 26
//     - 9-bit intermediate, no 8-bit overflow; key 0 = identity
//     - decrypt inverts every stage; shifts commute, so stage order stays 0..N-1
//       and decrypt(encrypt(x)) = x for identical keys
//   Case is preserved; non-letters never shift.
//   Error char: out_char=8'h00, flags set, out_valid still asserted (stream stays aligned).
//     Both flags may be set together.
//   err_count: +1 at each out_valid&&out_ready with (err_key||err_char);
//     holds at 2^ERR_CNT_W-1.
//   Stall: out_valid && !out_ready freezes every stage; no char is dropped or duplicated.
//   Reset mid-stream: in-flight chars are discarded; out_valid=0 immediately (async).
//   Simultaneous accept and deliver in the same cycle is legal at full rate.
// TESTING
//   N=3, keys {3,5,1} dir 000 enc, 'A'(0x41) -> out 'J'(0x4A) 3 cycles later, no err
//   Wrap: N=3, keys {1,0,0} right 'z'(0x7A) -> 'a'(0x61); same keys left 'a' -> 'z'; 'Z' right -> 'A'
//   Round trip: 52 letters enc then dec, keys {25,13,7} dir 101 -> every char restored
//   Errors:
//     - key field 26 -> out 0x00, err_key=1
//     - '#'(0x23) with PASS=0 -> err_char=1, err_count+1
//     - with PASS=1 -> '#' out unchanged, no count
//   Backpressure: 8 back-to-back chars, out_ready low cycles 4-9
//     -> in_ready low while full and stalled; all 8 out in order, none lost
//   Reset: assert rst_n=0 with 3 chars in flight -> out_valid 0 same cycle;
//     err_count 0; next char after release has 3-cycle latency

Source files
------------

// File: rtl/caesar_cipher_pipeline.sv
// Pipelined Caesar cipher: one capture stage followed by NUM_STAGES shift stages.
// Keys, direction and mode ride with each character; a single enable stalls the whole pipe.
module caesar_cipher_pipeline #(
  parameter int NUM_STAGES       = 3,
  parameter bit PASS_NON_LETTERS = 1'b0,
  parameter int ERR_CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_char,
  input  logic                    in_decrypt,
  input  logic [5*NUM_STAGES-1:0] in_key_num,
  input  logic [NUM_STAGES-1:0]   in_key_dir,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_char,
  output logic                    out_err_key,
  output logic                    out_err_char,
  output logic [ERR_CNT_W-1:0]    err_count
);

  typedef struct packed {
    logic                    valid;
    logic [7:0]              ch;
    logic                    upper;
    logic                    letter;
    logic                    decrypt;
    logic                    err_key;
    logic                    err_char;
    logic [5*NUM_STAGES-1:0] keys;
    logic [NUM_STAGES-1:0]   dirs;
  } stage_t;

  // Index 0 is the capture register; index i+1 holds the char after shift stage i.
  stage_t stage_q [NUM_STAGES+1];
  stage_t stage_d [NUM_STAGES+1];

  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 en;
  logic                 key_bad;
  logic                 in_upper, in_lower;

  // 9-bit arithmetic keeps the wrap comparison free of 8-bit overflow.
  function automatic logic [7:0] shift_char(input logic [7:0] c, input logic upper,
                                            input logic [4:0] k, input logic left);
    logic [8:0] c9;
    logic [8:0] lo;
    logic [8:0] hi;
    lo = upper ? 9'h041 : 9'h061;
    hi = upper ? 9'h05A : 9'h07A;
    if (left) begin
      c9 = {1'b0, c} - {4'b0, k};
      if (c9 < lo) c9 = c9 + 9'd26;
    end else begin
      c9 = {1'b0, c} + {4'b0, k};
      if (c9 > hi) c9 = c9 - 9'd26;
    end
    return c9[7:0];
  endfunction

  // NOTE: combinational logic uses blocking '=' with every output defaulted first,
  // so no latch can be inferred; the flops below use non-blocking '<=' only.
  always_comb begin
    en        = !stage_q[NUM_STAGES].valid || out_ready;
    in_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
    in_lower  = (in_char >= 8'h61) && (in_char <= 8'h7A);
    key_bad   = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (in_key_num[5*i +: 5] > 5'd25) key_bad = 1'b1;
    end

    for (int i = 0; i <= NUM_STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end

    if (en) begin
      stage_d[0].valid    = in_valid;
      stage_d[0].ch       = in_char;
      stage_d[0].upper    = in_upper;
      stage_d[0].letter   = in_upper || in_lower;
      stage_d[0].decrypt  = in_decrypt;
      stage_d[0].err_key  = key_bad;
      stage_d[0].err_char = !(in_upper || in_lower) && !PASS_NON_LETTERS;
      stage_d[0].keys     = in_key_num;
      stage_d[0].dirs     = in_key_dir;

      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_d[i+1] = stage_q[i];
        if (stage_q[i].letter) begin
          stage_d[i+1].ch = shift_char(stage_q[i].ch, stage_q[i].upper,
                                       stage_q[i].keys[5*i +: 5],
                                       stage_q[i].dirs[i] ^ stage_q[i].decrypt);
        end
      end

      if (stage_q[NUM_STAGES-1].err_key || stage_q[NUM_STAGES-1].err_char) begin
        stage_d[NUM_STAGES].ch = 8'h00;
      end
    end

    err_count_d = err_count_q;
    if (stage_q[NUM_STAGES].valid && out_ready &&
        (stage_q[NUM_STAGES].err_key || stage_q[NUM_STAGES].err_char) &&
        (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // NOTE: the pipeline registers are plain flops, not a RAM, so they are all reset;
  // this is what lets an async reset drop in-flight chars and out_valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      err_count_q <= '0;
    end else begin
      for (int i = 0; i <= NUM_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      err_count_q <= err_count_d;
    end
  end

  assign in_ready     = en;
  assign out_valid    = stage_q[NUM_STAGES].valid;
  assign out_char     = stage_q[NUM_STAGES].ch;
  assign out_err_key  = stage_q[NUM_STAGES].err_key;
  assign out_err_char = stage_q[NUM_STAGES].err_char;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_caesar_cipher_pipeline.sv
// Directed bench for caesar_cipher_pipeline (N=3): cipher values, wrap, round trip,
// error flags/counter, backpressure ordering and asynchronous reset mid-stream.
module tb_caesar_cipher_pipeline;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_decrypt;
  logic [14:0] in_key_num;
  logic [2:0]  in_key_dir;
  logic        out_ready;

  logic        in_ready, out_valid, out_err_key, out_err_char;
  logic [7:0]  out_char;
  logic [15:0] err_count;

  logic        p1_in_ready, p1_out_valid, p1_out_err_key, p1_out_err_char;
  logic [7:0]  p1_out_char;
  logic [15:0] p1_err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] r_char;
  logic       r_ek, r_ec;
  int         r_lat;
  logic [7:0] r_p1_char;
  logic       r_p1_ec;

  caesar_cipher_pipeline #(.NUM_STAGES(3), .PASS_NON_LETTERS(1'b0), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_decrypt(in_decrypt), .in_key_num(in_key_num),
    .in_key_dir(in_key_dir), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .out_err_key(out_err_key), .out_err_char(out_err_char),
    .err_count(err_count)
  );

  caesar_cipher_pipeline #(.NUM_STAGES(3), .PASS_NON_LETTERS(1'b1), .ERR_CNT_W(16)) dut_pass (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p1_in_ready),
    .in_char(in_char), .in_decrypt(in_decrypt), .in_key_num(in_key_num),
    .in_key_dir(in_key_dir), .out_valid(p1_out_valid), .out_ready(1'b1),
    .out_char(p1_out_char), .out_err_key(p1_out_err_key), .out_err_char(p1_out_err_char),
    .err_count(p1_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one char with an idle sink, then wait (bounded) for its result.
  task automatic xfer(input logic [7:0] c, input logic [14:0] k, input logic [2:0] d,
                      input logic dec);
    @(negedge clk);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_char    = c;
    in_key_num = k;
    in_key_dir = d;
    in_decrypt = dec;
    @(negedge clk);
    in_valid   = 1'b0;
    in_char    = 8'hFF;
    in_key_num = '1;
    r_lat = 0;
    while (!out_valid && r_lat < 20) begin
      @(negedge clk);
      r_lat++;
    end
    r_char    = out_char;
    r_ek      = out_err_key;
    r_ec      = out_err_char;
    r_p1_char = p1_out_char;
    r_p1_ec   = p1_out_err_char;
  endtask

  localparam logic [14:0] K_351  = {5'd1, 5'd5, 5'd3};
  localparam logic [14:0] K_100  = {5'd0, 5'd0, 5'd1};
  localparam logic [14:0] K_RT   = {5'd7, 5'd13, 5'd25};
  localparam logic [14:0] K_BAD  = {5'd0, 5'd26, 5'd0};

  logic [7:0] c, enc;
  logic [7:0] got [8];
  int         n_got, n_sent;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_char    = 8'h00;
    in_decrypt = 1'b0;
    in_key_num = '0;
    in_key_dir = '0;
    out_ready  = 1'b1;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_char", out_char, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_flags", {out_err_key, out_err_char}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    xfer(8'h41, K_351, 3'b000, 1'b0);
    check("enc_A_char", r_char, 8'h4A);
    check("enc_A_lat", r_lat, 3);
    check("enc_A_flags", {r_ek, r_ec}, 0);
    xfer(8'h4A, K_351, 3'b000, 1'b1);
    check("dec_J_char", r_char, 8'h41);

    xfer(8'h7A, K_100, 3'b000, 1'b0);
    check("wrap_z_right", r_char, 8'h61);
    xfer(8'h61, K_100, 3'b001, 1'b0);
    check("wrap_a_left", r_char, 8'h7A);
    xfer(8'h5A, K_100, 3'b000, 1'b0);
    check("wrap_Z_right", r_char, 8'h41);

    xfer(8'h41, K_RT, 3'b101, 1'b0);
    check("mix_A_enc", r_char, 8'h48);
    xfer(8'h7A, K_RT, 3'b101, 1'b0);
    check("mix_z_enc", r_char, 8'h67);

    for (int i = 0; i < 52; i++) begin
      c = (i < 26) ? 8'(8'h41 + i) : 8'(8'h61 + i - 26);
      xfer(c, K_RT, 3'b101, 1'b0);
      enc = r_char;
      xfer(enc, K_RT, 3'b101, 1'b1);
      check($sformatf("roundtrip_%0d", i), r_char, c);
    end

    xfer(8'h23, K_351, 3'b000, 1'b0);
    check("hash_char", r_char, 8'h00);
    check("hash_flags", {r_ek, r_ec}, 2'b01);
    check("pass_hash_char", r_p1_char, 8'h23);
    check("pass_hash_flag", r_p1_ec, 0);
    @(negedge clk);
    check("hash_count", err_count, 1);
    check("pass_count", p1_err_count, 0);

    xfer(8'h41, K_BAD, 3'b000, 1'b0);
    check("badkey_char", r_char, 8'h00);
    check("badkey_flags", {r_ek, r_ec}, 2'b10);
    @(negedge clk);
    check("badkey_count", err_count, 2);

    xfer(8'h23, K_BAD, 3'b000, 1'b0);
    check("both_flags", {r_ek, r_ec}, 2'b11);
    @(negedge clk);
    check("both_count", err_count, 3);

    in_key_num = K_100;
    in_key_dir = 3'b000;
    in_decrypt = 1'b0;
    n_got  = 0;
    n_sent = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 9);
      #1;
      if (cyc < 10) check($sformatf("bp_in_ready_%0d", cyc), in_ready, !(cyc >= 4 && cyc <= 9));
      if (cyc >= 4 && cyc <= 9) check($sformatf("bp_hold_%0d", cyc), out_char, 8'h42);
      if (out_valid && out_ready && n_got < 8) begin
        got[n_got] = out_char;
        n_got++;
      end
      if (n_sent < 8) begin
        in_valid = 1'b1;
        in_char  = 8'(8'h41 + n_sent);
        if (in_ready) n_sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_count", n_got, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_order_%0d", i), got[i], 8'(8'h42 + i));
    end

    @(negedge clk);
    out_ready  = 1'b0;
    in_key_num = K_351;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_char  = 8'(8'h61 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rst_inflight_empty_out", out_valid, 0);
    @(negedge clk);
    check("rst_inflight_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_err_count", err_count, 0);
    check("rst_mid_out_char", out_char, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    xfer(8'h41, K_351, 3'b000, 1'b0);
    check("post_rst_char", r_char, 8'h4A);
    check("post_rst_lat", r_lat, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
